amplitude_meter: RTL and testbench

AMPLITUDE_METER -- requirements
Module: amplitude_meter

---
 rtl/audio_pkg.sv | 10 +
 rtl/peak_hold.sv | 32 +++
 rtl/amplitude_meter.sv | 96 +++++++++
 tb/tb_amplitude_meter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared widths and FSM state type for the amplitude meter datapath.
package audio_pkg;
  localparam int SAMPLE_W   = 12;
  localparam int WINDOW_LEN = 16;
  localparam int LEVEL_W    = 4;
  localparam int IDX_W      = $clog2(WINDOW_LEN);
  localparam int SUM_W      = SAMPLE_W + IDX_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} meter_state_t;
endpackage

// File: rtl/peak_hold.sv
// Peak-held bar height: jumps up to a louder level immediately, then decays
// one step after every DECAY_WINDOWS results without a new peak.
module peak_hold import audio_pkg::*; #(
  parameter int DECAY_WINDOWS = 8
) (
  input  logic               clk_10MHz,
  input  logic               rst,
  input  logic               done,
  input  logic [LEVEL_W-1:0] new_level,
  output logic [LEVEL_W-1:0] peak_level
);
  localparam int CNT_W = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;

  logic [CNT_W-1:0] decay_cnt;

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      peak_level <= '0;
      decay_cnt  <= '0;
    end else if (done) begin
      if (new_level > peak_level) begin
        peak_level <= new_level;
        decay_cnt  <= '0;
      end else if (decay_cnt == CNT_W'(DECAY_WINDOWS - 1)) begin
        if (peak_level != '0) peak_level <= peak_level - 1'b1;
        decay_cnt <= '0;
      end else begin
        decay_cnt <= decay_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/amplitude_meter.sv
// Windowed amplitude meter: snapshots 16 samples, then walks them one per
// cycle for min/max/sum. Define AMPLITUDE_METER_PEAK_HOLD_EN for peak hold.
module amplitude_meter import audio_pkg::*; #(
  parameter int DECAY_WINDOWS = 8
) (
  input  logic                clk_10MHz,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] samples [0:WINDOW_LEN-1],
  input  logic                sample_valid,
  output logic                busy,
  output logic                result_valid,
  output logic [SAMPLE_W-1:0] p2p,
  output logic [SAMPLE_W-1:0] mean,
  output logic [LEVEL_W-1:0]  level,
  output logic [LEVEL_W-1:0]  peak_level,
  output logic                overrun
);
  meter_state_t        state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [SAMPLE_W-1:0] snap [0:WINDOW_LEN-1];
  logic [SAMPLE_W-1:0] cur_sample, min_q, max_q, diff;
  logic [SUM_W-1:0]    sum_q;

  assign busy       = (state != IDLE);
  assign cur_sample = snap[idx];
  assign diff       = max_q - min_q;
  assign level      = p2p[SAMPLE_W-1 -: LEVEL_W];

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid) state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_W'(WINDOW_LEN - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot isolates the result from window shifts during ACCUM.
  always_ff @(posedge clk_10MHz) begin
    if (state == IDLE && sample_valid) snap <= samples;
  end

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      min_q        <= '1;
      max_q        <= '0;
      sum_q        <= '0;
      p2p          <= '0;
      mean         <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (sample_valid && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_valid) begin
          idx   <= '0;
          min_q <= '1;
          max_q <= '0;
          sum_q <= '0;
        end
        ACCUM: begin
          if (cur_sample < min_q) min_q <= cur_sample;
          if (cur_sample > max_q) max_q <= cur_sample;
          sum_q <= sum_q + SUM_W'(cur_sample);
          idx   <= idx + 1'b1;
        end
        DONE: begin
          p2p          <= diff;
          mean         <= sum_q[SUM_W-1 -: SAMPLE_W];
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AMPLITUDE_METER_PEAK_HOLD_EN
  peak_hold #(.DECAY_WINDOWS(DECAY_WINDOWS)) u_peak_hold (
    .clk_10MHz  (clk_10MHz),
    .rst        (rst),
    .done       (state == DONE),
    .new_level  (diff[SAMPLE_W-1 -: LEVEL_W]),
    .peak_level (peak_level)
  );
`else
  assign peak_level = level;
`endif
endmodule

// File: tb/tb_amplitude_meter.sv
// Randomized bench for amplitude_meter against a window-level reference model.
module tb_amplitude_meter;
  localparam int DW = 8;

  logic        clk_10MHz = 1'b0;
  logic        rst;
  logic [11:0] samples [0:15];
  logic        sample_valid;
  logic        busy, result_valid, overrun;
  logic [11:0] p2p, mean;
  logic [3:0]  level, peak_level;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [11:0] win [0:15];
  int m_p2p = 0, m_mean = 0, m_peak = 0, m_cnt = 0;
  bit m_overrun = 1'b0;

  amplitude_meter #(.DECAY_WINDOWS(DW)) dut (
    .clk_10MHz    (clk_10MHz),
    .rst          (rst),
    .samples      (samples),
    .sample_valid (sample_valid),
    .busy         (busy),
    .result_valid (result_valid),
    .p2p          (p2p),
    .mean         (mean),
    .level        (level),
    .peak_level   (peak_level),
    .overrun      (overrun)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_result();
    int mx = 0, mn = 4095, sum = 0, lvl;
    for (int i = 0; i < 16; i++) begin
      if (int'(win[i]) > mx) mx = int'(win[i]);
      if (int'(win[i]) < mn) mn = int'(win[i]);
      sum += int'(win[i]);
    end
    m_p2p  = mx - mn;
    m_mean = sum / 16;
    lvl    = m_p2p / 256;
`ifdef AMPLITUDE_METER_PEAK_HOLD_EN
    if (lvl > m_peak) begin
      m_peak = lvl;
      m_cnt  = 0;
    end else begin
      m_cnt++;
      if (m_cnt == DW) begin
        if (m_peak > 0) m_peak--;
        m_cnt = 0;
      end
    end
`else
    m_peak = lvl;
`endif
  endfunction

  function automatic void model_reset();
    m_p2p = 0; m_mean = 0; m_peak = 0; m_cnt = 0; m_overrun = 1'b0;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 16; i++) samples[i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_p2p"},     int'(p2p),        m_p2p);
    chk({tag, "_mean"},    int'(mean),       m_mean);
    chk({tag, "_level"},   int'(level),      m_p2p / 256);
    chk({tag, "_peak"},    int'(peak_level), m_peak);
    chk({tag, "_overrun"}, int'(overrun),    int'(m_overrun));
  endtask

  // Offers win to the DUT; dup_at>0 injects a second pulse that many cycles later.
  task automatic run_window(input string tag, input int dup_at);
    int lat = -1;
    int pulses = 0;
    @(negedge clk_10MHz);
    for (int i = 0; i < 16; i++) samples[i] = win[i];
    sample_valid = 1'b1;
    @(posedge clk_10MHz); #1;
    chk({tag, "_busy_accept"}, int'(busy), 1);
    @(negedge clk_10MHz);
    sample_valid = 1'b0;
    scramble();
    model_result();
    if (dup_at > 0) m_overrun = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_10MHz); #1;
      if (result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          chk({tag, "_busy_done"}, int'(busy), 0);
          chk_outputs(tag);
        end
      end
      @(negedge clk_10MHz);
      sample_valid = (k + 1 == dup_at);
      scramble();
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_pulses"}, pulses, 1);
    chk_outputs({tag, "_hold"});
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    scramble();
    @(negedge clk_10MHz);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rv",   int'(result_valid), 0);
    chk_outputs("rst");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) win[i] = 12'd2048;
    run_window("const2048", 0);
    chk("const2048_p2p_abs",  int'(p2p), 0);
    chk("const2048_mean_abs", int'(mean), 2048);
    chk("const2048_lvl_abs",  int'(level), 0);

    for (int i = 0; i < 16; i++) win[i] = (i % 2) ? 12'd4095 : 12'd0;
    run_window("alt", 0);
    chk("alt_p2p_abs",  int'(p2p), 4095);
    chk("alt_mean_abs", int'(mean), 2047);
    chk("alt_lvl_abs",  int'(level), 15);

    for (int i = 0; i < 16; i++) win[i] = 12'(i * 256);
    run_window("ramp", 0);
    chk("ramp_p2p_abs",  int'(p2p), 3840);
    chk("ramp_mean_abs", int'(mean), 1920);
    chk("ramp_lvl_abs",  int'(level), 15);

    for (int r = 0; r < 3; r++) begin
      logic [11:0] c;
      c = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 16; i++) win[i] = c;
      run_window("rand_const", 0);
      chk("rand_const_p2p", int'(p2p), 0);
      chk("rand_const_mean", int'(mean), int'(c));
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(0, 4095));
      run_window("rand", 0);
    end

    for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(0, 4095));
    run_window("dup", 5);
    chk("dup_overrun", int'(overrun), 1);
    for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(0, 4095));
    run_window("after_dup", 0);
    chk("after_dup_overrun", int'(overrun), 1);

    // abort mid-window: reset lands after the 8th processing edge
    begin
      int pulses = 0;
      @(negedge clk_10MHz);
      for (int i = 0; i < 16; i++) samples[i] = 12'($urandom_range(0, 4095));
      sample_valid = 1'b1;
      @(negedge clk_10MHz);
      sample_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk_10MHz); #1;
        if (result_valid) pulses++;
      end
      @(negedge clk_10MHz);
      rst = 1'b1;
      model_reset();
      #1;
      chk("abort_busy", int'(busy), 0);
      chk_outputs("abort");
      @(negedge clk_10MHz);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk_10MHz); #1;
        if (result_valid) pulses++;
      end
      chk("abort_no_result", pulses, 0);
      chk_outputs("abort_idle");
    end
    for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(0, 4095));
    run_window("post_abort", 0);

    // peak-hold sequence from a clean state
    @(negedge clk_10MHz);
    rst = 1'b1;
    model_reset();
    @(negedge clk_10MHz);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) win[i] = (i % 2) ? 12'd3072 : 12'd0;
    run_window("lvl12", 0);
    chk("lvl12_level_abs", int'(level), 12);
`ifdef AMPLITUDE_METER_PEAK_HOLD_EN
    chk("peak_start_abs", int'(peak_level), 12);
`endif
    for (int w = 1; w <= 16; w++) begin
      logic [11:0] c;
      c = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 16; i++) win[i] = c;
      run_window("quiet", 0);
`ifdef AMPLITUDE_METER_PEAK_HOLD_EN
      if (w == 8)  chk("peak_after8_abs",  int'(peak_level), 11);
      if (w == 16) chk("peak_after16_abs", int'(peak_level), 10);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
